// File: rtl/key_mem.sv
// AES-128 round-key store: 11 round keys read with one cycle of latency.
// Define KEYMEM_EXPAND_EN to expand CIPHER_KEY on chip instead of the ROM.
module key_mem #(
    parameter logic [127:0] CIPHER_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c,
    parameter int           NROUNDS    = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [3:0]   add,
    output logic [127:0] dout,
    output logic         ready
);

    localparam logic [3:0] LAST = 4'(NROUNDS);

    logic [127:0] rd_key;

`ifdef KEYMEM_EXPAND_EN

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t       state;
    logic [3:0]   r;
    logic [127:0] w;
    logic [127:0] nxt;
    logic [31:0]  temp;
    logic [127:0] rk [0:NROUNDS];

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        case (x)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
            8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
            8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
            8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
            8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
            8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
            8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
            8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
            8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
            8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
            8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
            8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
            8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
            8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
            8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
            8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
            8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
            8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
            8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
            8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
            8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
            8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
            8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
            8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
            8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
            8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
            8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
            8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
            8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
            8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
            8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
            8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
            8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] c;
        case (i)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    // temp = SubWord(RotWord(w3)) ^ Rcon; then chain the four words
    always_comb begin
        temp = {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])}
             ^ {rcon(r), 24'h0};
        nxt[127:96] = w[127:96] ^ temp;
        nxt[95:64]  = w[95:64]  ^ nxt[127:96];
        nxt[63:32]  = w[63:32]  ^ nxt[95:64];
        nxt[31:0]   = w[31:0]   ^ nxt[63:32];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            r     <= 4'd0;
            w     <= 128'h0;
            ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    w     <= CIPHER_KEY;
                    r     <= 4'd1;
                    state <= EXPAND;
                end
                EXPAND: begin
                    w <= nxt;
                    if (r == LAST) begin
                        state <= DONE;
                        ready <= 1'b1;
                    end else begin
                        r <= r + 4'd1;
                    end
                end
                DONE:    ready <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    // Key storage carries no reset; ready gates every read.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state == IDLE)
                rk[0] <= CIPHER_KEY;
            else if (state == EXPAND)
                rk[r] <= nxt;
        end
    end

    always_comb begin
        rd_key = 128'h0;
        if (add <= LAST)
            rd_key = rk[add];
    end

`else

    // Entry 0 is the cipher key itself; the rest is the default key schedule.
    always_comb begin
        case (add)
            4'd0:    rd_key = CIPHER_KEY;
            4'd1:    rd_key = 128'ha0fafe1788542cb123a339392a6c7605;
            4'd2:    rd_key = 128'hf2c295f27a96b9435935807a7359f67f;
            4'd3:    rd_key = 128'h3d80477d4716fe3e1e237e446d7a883b;
            4'd4:    rd_key = 128'hef44a541a8525b7fb671253bdb0bad00;
            4'd5:    rd_key = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
            4'd6:    rd_key = 128'h6d88a37a110b3efddbf98641ca0093fd;
            4'd7:    rd_key = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
            4'd8:    rd_key = 128'head27321b58dbad2312bf5607f8d292f;
            4'd9:    rd_key = 128'hac7766f319fadc2128d12941575c006e;
            4'd10:   rd_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            default: rd_key = 128'h0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset)
            ready <= 1'b0;
        else
            ready <= 1'b1;
    end

`endif

    always_ff @(posedge clock) begin
        if (!reset)
            dout <= 128'h0;
        else if (en)
            dout <= (ready && add <= LAST) ? rd_key : 128'h0;
    end

endmodule

// File: tb/tb_key_mem.sv
// Scoreboard bench for key_mem; ROM build by default, expansion build
// (with a second zero-key instance) when KEYMEM_EXPAND_EN is defined.
module tb_key_mem;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic [3:0]   add = 4'd0;
    logic [127:0] dout;
    logic         ready;

    always #5 clock = ~clock;

    key_mem dut (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .add   (add),
        .dout  (dout),
        .ready (ready)
    );

`ifdef KEYMEM_EXPAND_EN
    localparam int LAT = 11;
    logic [127:0] dout0;
    logic         ready0;
    key_mem #(.CIPHER_KEY(128'h0)) dut0 (
        .clock (clock),
        .reset (reset),
        .en    (en),
        .add   (add),
        .dout  (dout0),
        .ready (ready0)
    );
`else
    localparam int LAT = 1;
`endif

    logic [127:0] tbl [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        string        name;
        logic [127:0] d;
        logic         r;
        bit           c0;
        logic [127:0] d0;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    logic [127:0] dm = 128'h0;
    logic [127:0] d0m = 128'h0;
    bit           k0 = 1'b1;
    int           cnt = 0;

    function automatic logic [127:0] zero_key(input int a, output bit known);
        known = 1'b1;
        case (a)
            0:  return 128'h0;
            1:  return 128'h62636363626363636263636362636363;
            10: return 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
            default: begin
                known = 1'b0;
                return 128'h0;
            end
        endcase
    endfunction

    task automatic step(input logic rst, input logic e, input int a, input string nm);
        exp_t x;
        bit rb;
        bit kn;
        logic [127:0] z;
        @(negedge clock);
        reset = rst;
        en    = e;
        add   = 4'(a);
        if (!rst) begin
            dm  = 128'h0;
            d0m = 128'h0;
            k0  = 1'b1;
            cnt = 0;
        end else begin
            rb = (cnt >= LAT);
            cnt++;
            if (e) begin
                if (rb && a <= 10) begin
                    dm  = tbl[a];
                    z   = zero_key(a, kn);
                    d0m = z;
                    k0  = kn;
                end else begin
                    dm  = 128'h0;
                    d0m = 128'h0;
                    k0  = 1'b1;
                end
            end
        end
        x.name = nm;
        x.d    = dm;
        x.r    = rst && (cnt >= LAT);
        x.c0   = k0;
        x.d0   = d0m;
        q.push_back(x);
    endtask

    always @(posedge clock) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (dout !== x.d) begin
                failures++;
                $display("FAIL %s dout got=%h want=%h", x.name, dout, x.d);
            end
            checks++;
            if (ready !== x.r) begin
                failures++;
                $display("FAIL %s ready got=%b want=%b", x.name, ready, x.r);
            end
`ifdef KEYMEM_EXPAND_EN
            checks++;
            if (ready0 !== x.r) begin
                failures++;
                $display("FAIL %s ready0 got=%b want=%b", x.name, ready0, x.r);
            end
            if (x.c0) begin
                checks++;
                if (dout0 !== x.d0) begin
                    failures++;
                    $display("FAIL %s dout0 got=%h want=%h", x.name, dout0, x.d0);
                end
            end
`endif
        end
    end

    initial begin
        step(1'b0, 1'b1, 5, "t1_reset");
        step(1'b0, 1'b1, 5, "t1_reset");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, 0, "t5_partial");
        step(1'b0, 1'b1, 0, "t5_midreset");
        for (int i = 0; i < LAT + 2; i++)
            step(1'b1, 1'b1, 0, "t5_ramp");
        for (int a = 0; a <= 10; a++)
            step(1'b1, 1'b1, a, "t2_sweep");
        for (int a = 11; a <= 15; a++)
            step(1'b1, 1'b1, a, "t3_oor");
        step(1'b1, 1'b1, 3, "t3_back");
        step(1'b1, 1'b1, 7, "t4_read");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 2, "t4_hold");
        step(1'b1, 1'b1, 2, "t4_resume");
        step(1'b1, 1'b1, 10, "edge_last");
        step(1'b1, 1'b1, 11, "edge_over");
        step(1'b1, 1'b1, 1, "edge_one");
        step(1'b0, 1'b1, 1, "reset_wins");
        step(1'b1, 1'b0, 4, "post_hold");
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
